// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first ripple-borrow subtractor with a start/busy/done handshake.
// Optional macro SUB_OVERFLOW_FLAG_EN adds a signed-overflow output ovf.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] minuend,
  input  logic [WIDTH-1:0] subtrahend,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             busy,
  output logic             done
`ifdef SUB_OVERFLOW_FLAG_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  // Handshake: start is only sampled in IDLE; busy covers RUN and DONE;
  // done is a single-cycle pulse, and diff/borrow_out are valid from then on.
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d, bout_q, bout_d;
  logic             bit_d, br_nx;
`ifdef SUB_OVERFLOW_FLAG_EN
  logic             amsb_q, amsb_d, bmsb_q, bmsb_d, ovf_q, ovf_d;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    bout_d  = bout_q;
`ifdef SUB_OVERFLOW_FLAG_EN
    amsb_d  = amsb_q;
    bmsb_d  = bmsb_q;
    ovf_d   = ovf_q;
`endif
    bit_d   = a_q[0] ^ b_q[0] ^ br_q;
    br_nx   = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = minuend;
          b_d     = subtrahend;
          br_d    = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
`ifdef SUB_OVERFLOW_FLAG_EN
          amsb_d  = minuend[WIDTH-1];
          bmsb_d  = subtrahend[WIDTH-1];
`endif
        end
      end
      RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        res_d = {bit_d, res_q[WIDTH-1:1]};
        br_d  = br_nx;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          // Final bit: publish the completed result alongside the final borrow.
          state_d = DONE;
          diff_d  = res_d;
          bout_d  = br_nx;
`ifdef SUB_OVERFLOW_FLAG_EN
          ovf_d   = (amsb_q ^ bmsb_q) & (bit_d ^ amsb_q);
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
`ifdef SUB_OVERFLOW_FLAG_EN
      amsb_q  <= 1'b0;
      bmsb_q  <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
`ifdef SUB_OVERFLOW_FLAG_EN
      amsb_q  <= amsb_d;
      bmsb_q  <= bmsb_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign diff       = diff_q;
  assign borrow_out = bout_q;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
`ifdef SUB_OVERFLOW_FLAG_EN
  assign ovf        = ovf_q;
`endif

endmodule
